// File: rtl/alu_multicycle_pkg.sv
// Opcodes, FSM states and iterative-unit modes shared by the multi-cycle ALU files.
package alu_multicycle_pkg;

    localparam int ALU_OPRN_WIDTH = 6;

    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OP_ADD  = 6'h01;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OP_SUB  = 6'h02;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OP_MUL  = 6'h03;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OP_SHL  = 6'h04;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OP_SHR  = 6'h05;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OP_AND  = 6'h06;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OP_OR   = 6'h07;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OP_NOR  = 6'h08;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OP_SLT  = 6'h09;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OP_SLTU = 6'h0A;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    typedef enum logic [1:0] {
        MODE_MUL,
        MODE_SHL,
        MODE_SHR
    } iter_mode_e;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the execute stage and the multi-cycle ALU.
interface alu_multicycle_if
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int OPRN_WIDTH = ALU_OPRN_WIDTH
);

    logic                  start;
    logic [OPRN_WIDTH-1:0] oprn;
    logic [WIDTH-1:0]      op1;
    logic [WIDTH-1:0]      op2;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      out;
    logic [WIDTH-1:0]      out_hi;
    logic                  zero;
    logic                  err;

    modport master (
        output start, oprn, op1, op2,
        input  busy, done, out, out_hi, zero, err
    );

    modport slave (
        input  start, oprn, op1, op2,
        output busy, done, out, out_hi, zero, err
    );

endinterface

// File: rtl/alu_multicycle_iter_unit.sv
// Shift-add multiplier and bit-serial shifter; load performs the first step so the
// last step lands one edge before the top commits the result.
module alu_multicycle_iter_unit
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  iter_mode_e       mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             count_zero
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic [CW-1:0]    count_q, count_d;
    iter_mode_e       mode_q, mode_d;

    logic [WIDTH-1:0] src_hi, src_lo, src_mcand;
    iter_mode_e       src_mode;
    logic [WIDTH:0]   sum;

    always_comb begin
        if (load) begin
            src_mode  = mode;
            src_mcand = op_a;
            src_hi    = '0;
            src_lo    = (mode == MODE_MUL) ? op_b : op_a;
        end else begin
            src_mode  = mode_q;
            src_mcand = mcand_q;
            src_hi    = hi_q;
            src_lo    = lo_q;
        end

        sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_mcand} : '0);

        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        mode_d  = mode_q;
        count_d = count_q;

        if (load || step) begin
            mcand_d = src_mcand;
            mode_d  = src_mode;
            case (src_mode)
                MODE_MUL: begin
                    hi_d = sum[WIDTH:1];
                    lo_d = {sum[0], src_lo[WIDTH-1:1]};
                end
                MODE_SHL: begin
                    hi_d = '0;
                    lo_d = {src_lo[WIDTH-2:0], 1'b0};
                end
                default: begin
                    hi_d = '0;
                    lo_d = {1'b0, src_lo[WIDTH-1:1]};
                end
            endcase
        end

        // Count holds the steps still to do after the one performed at load.
        if (load) begin
            count_d = (mode == MODE_MUL) ? CW'(WIDTH - 1) : op_b[CW-1:0] - 1'b1;
        end else if (step) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            mode_q  <= MODE_MUL;
            count_q <= '0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    assign acc_hi     = hi_q;
    assign acc_lo     = lo_q;
    assign count_zero = (count_q == '0);

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: FSM, single-cycle ops and result registers; DONE rises
// exactly N edges after the accepting edge, N being the op's latency.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int OPRN_WIDTH = ALU_OPRN_WIDTH
) (
    input logic             clk,
    input logic             rst,
    alu_multicycle_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             busy_q, busy_d, done_q, done_d, zero_q, zero_d, err_q, err_d;
    logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
    logic             pend_valid_q, pend_valid_d, pend_err_q, pend_err_d;
    logic [WIDTH-1:0] pend_out_q, pend_out_d;

    logic [OPRN_WIDTH-1:0] oprn;
    logic [WIDTH-1:0]      op1, op2, single_res, acc_hi, acc_lo;
    logic                  illegal, shamt_zero, shamt_big, multi;
    logic                  iter_load, iter_step, count_zero;
    iter_mode_e            iter_mode;

    assign oprn = bus.oprn;
    assign op1  = bus.op1;
    assign op2  = bus.op2;

    always_comb begin
        shamt_zero = (op2 == '0);
        shamt_big  = |op2[WIDTH-1:CW];
        illegal    = 1'b0;
        multi      = 1'b0;
        iter_mode  = MODE_SHR;
        single_res = '0;
        case (oprn)
            ALU_OP_ADD:  single_res = op1 + op2;
            ALU_OP_SUB:  single_res = op1 - op2;
            ALU_OP_MUL: begin
                multi     = 1'b1;
                iter_mode = MODE_MUL;
            end
            ALU_OP_SHL: begin
                multi      = !shamt_zero && !shamt_big;
                iter_mode  = MODE_SHL;
                single_res = shamt_big ? '0 : op1;
            end
            ALU_OP_SHR: begin
                multi      = !shamt_zero && !shamt_big;
                iter_mode  = MODE_SHR;
                single_res = shamt_big ? '0 : op1;
            end
            ALU_OP_AND:  single_res = op1 & op2;
            ALU_OP_OR:   single_res = op1 | op2;
            ALU_OP_NOR:  single_res = ~(op1 | op2);
            ALU_OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            default:     illegal = 1'b1;
        endcase
    end

    // Single-cycle results wait one edge in the pending stage, which keeps
    // their latency equal to a one-step shift without raising BUSY.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        out_d        = out_q;
        out_hi_d     = out_hi_q;
        zero_d       = zero_q;
        err_d        = err_q;
        pend_valid_d = 1'b0;
        pend_out_d   = pend_out_q;
        pend_err_d   = pend_err_q;
        iter_load    = 1'b0;
        iter_step    = 1'b0;

        if (pend_valid_q) begin
            done_d   = 1'b1;
            out_d    = pend_out_q;
            out_hi_d = '0;
            err_d    = pend_err_q;
            zero_d   = !pend_err_q && (pend_out_q == '0);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (multi) begin
                        iter_load = 1'b1;
                        state_d   = ST_RUN;
                        busy_d    = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_out_d   = single_res;
                        pend_err_d   = illegal;
                    end
                end
            end
            default: begin
                if (count_zero) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    out_d    = acc_lo;
                    out_hi_d = acc_hi;
                    err_d    = 1'b0;
                    zero_d   = (acc_lo == '0);
                end else begin
                    iter_step = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_q        <= '0;
            out_hi_q     <= '0;
            zero_q       <= 1'b1;
            err_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_out_q   <= '0;
            pend_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            out_q        <= out_d;
            out_hi_q     <= out_hi_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
            pend_valid_q <= pend_valid_d;
            pend_out_q   <= pend_out_d;
            pend_err_q   <= pend_err_d;
        end
    end

    alu_multicycle_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .rst        (rst),
        .load       (iter_load),
        .step       (iter_step),
        .mode       (iter_mode),
        .op_a       (op1),
        .op_b       (op2),
        .acc_hi     (acc_hi),
        .acc_lo     (acc_lo),
        .count_zero (count_zero)
    );

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.out    = out_q;
    assign bus.out_hi = out_hi_q;
    assign bus.zero   = zero_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle at WIDTH=32 with hand-computed results and latencies.
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;
    int   lat;
    int   busyCnt;
    logic [31:0] heldOut;

    alu_multicycle_if #(.WIDTH(WIDTH)) bus ();

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Presents one request for exactly one edge, then scrambles the operands.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.oprn  = op;
        bus.op1   = a;
        bus.op2   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.oprn  = 6'h3F;
        bus.op1   = ~a;
        bus.op2   = ~b;
        busyCnt   = bus.busy ? 1 : 0;
    endtask

    task automatic waitDone(input int budget);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busyCnt++;
        end while (!bus.done && lat < budget);
        if (!bus.done) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic runOp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(op, a, b);
        waitDone(200);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.oprn  = '0;
        bus.op1   = '0;
        bus.op2   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy",   64'(bus.busy),   64'd0);
        checkOutput("rst_done",   64'(bus.done),   64'd0);
        checkOutput("rst_out",    64'(bus.out),    64'd0);
        checkOutput("rst_out_hi", 64'(bus.out_hi), 64'd0);
        checkOutput("rst_zero",   64'(bus.zero),   64'd1);
        checkOutput("rst_err",    64'(bus.err),    64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        runOp(ALU_OP_ADD, 32'd2, 32'd3);
        checkOutput("add_lat",  64'(lat),      64'd1);
        checkOutput("add_out",  64'(bus.out),  64'd5);
        checkOutput("add_zero", 64'(bus.zero), 64'd0);
        checkOutput("add_busy", 64'(busyCnt),  64'd0);

        // Abort a multiply with reset after its fifth cycle.
        applyStimulus(ALU_OP_MUL, 32'd7, 32'd9);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid_mul_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #2;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_out",  64'(bus.out),  64'd0);
        checkOutput("abort_zero", 64'(bus.zero), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        runOp(ALU_OP_ADD, 32'hFFFF_FFFF, 32'd1);
        checkOutput("wrap_lat",  64'(lat),      64'd1);
        checkOutput("wrap_out",  64'(bus.out),  64'd0);
        checkOutput("wrap_zero", 64'(bus.zero), 64'd1);

        runOp(ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1);
        checkOutput("slt_out", 64'(bus.out), 64'd1);
        runOp(ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        checkOutput("sltu_out", 64'(bus.out), 64'd0);
        runOp(ALU_OP_SUB, 32'd3, 32'd5);
        checkOutput("sub_out", 64'(bus.out), 64'hFFFF_FFFE);
        runOp(ALU_OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
        checkOutput("and_out", 64'(bus.out), 64'h0000_F000);
        runOp(ALU_OP_OR, 32'h0000_F0F0, 32'h0000_FF00);
        checkOutput("or_out", 64'(bus.out), 64'h0000_FFF0);
        runOp(ALU_OP_NOR, 32'd0, 32'd0);
        checkOutput("nor_out", 64'(bus.out), 64'hFFFF_FFFF);

        // START held high with an add during the multiply must be ignored.
        applyStimulus(ALU_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.start = 1'b1;
        bus.oprn  = ALU_OP_ADD;
        bus.op1   = 32'd1;
        bus.op2   = 32'd1;
        waitDone(200);
        checkOutput("mul_lat",    64'(lat),        64'd32);
        checkOutput("mul_busy",   64'(busyCnt),    64'd32);
        checkOutput("mul_out",    64'(bus.out),    64'h0000_0001);
        checkOutput("mul_out_hi", 64'(bus.out_hi), 64'hFFFF_FFFE);
        checkOutput("mul_zero",   64'(bus.zero),   64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busyCnt   = 0;
        waitDone(10);
        checkOutput("b2b_lat",    64'(lat),        64'd1);
        checkOutput("b2b_out",    64'(bus.out),    64'd2);
        checkOutput("b2b_out_hi", 64'(bus.out_hi), 64'd0);

        runOp(ALU_OP_MUL, 32'h1234_5678, 32'h0000_0010);
        checkOutput("mul2_out",    64'(bus.out),    64'h2345_6780);
        checkOutput("mul2_out_hi", 64'(bus.out_hi), 64'h0000_0001);

        runOp(6'h3F, 32'd5, 32'd6);
        checkOutput("ill_lat",    64'(lat),        64'd1);
        checkOutput("ill_err",    64'(bus.err),    64'd1);
        checkOutput("ill_out",    64'(bus.out),    64'd0);
        checkOutput("ill_out_hi", 64'(bus.out_hi), 64'd0);
        checkOutput("ill_zero",   64'(bus.zero),   64'd0);
        runOp(ALU_OP_ADD, 32'd1, 32'd1);
        checkOutput("err_clear", 64'(bus.err), 64'd0);
        checkOutput("err_out",   64'(bus.out), 64'd2);

        runOp(ALU_OP_SHL, 32'd1, 32'd31);
        checkOutput("shl31_lat",  64'(lat),      64'd31);
        checkOutput("shl31_busy", 64'(busyCnt),  64'd31);
        checkOutput("shl31_out",  64'(bus.out),  64'h8000_0000);
        runOp(ALU_OP_SHR, 32'h8000_0000, 32'd40);
        checkOutput("shr40_lat", 64'(lat),     64'd1);
        checkOutput("shr40_out", 64'(bus.out), 64'd0);
        runOp(ALU_OP_SHL, 32'h0000_00A5, 32'd0);
        checkOutput("shl0_lat", 64'(lat),     64'd1);
        checkOutput("shl0_out", 64'(bus.out), 64'h0000_00A5);
        runOp(ALU_OP_SHR, 32'h8000_0000, 32'd4);
        checkOutput("shr4_lat",  64'(lat),     64'd4);
        checkOutput("shr4_busy", 64'(busyCnt), 64'd4);
        checkOutput("shr4_out",  64'(bus.out), 64'h0800_0000);

        heldOut = bus.out;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_done", 64'(bus.done), 64'd0);
        checkOutput("hold_out",  64'(bus.out),  64'(heldOut));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
